// File: rtl/hex_bcd_display.sv
// Binary to BCD converter (double-dabble, one bit per cycle) driving DIGITS seven-segment digits
// with optional leading-zero blanking and an overflow dash display.
module hex_bcd_display #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DIGITS     = 3,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [WIDTH-1:0]      i_bin,
   input  logic                  i_blank_lz,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_ovf,
   output logic [7*DIGITS-1:0]   o_hex
);

   // Accumulator is wide enough for any WIDTH-bit value, even when fewer digits are shown.
   localparam int unsigned NI_MIN = (WIDTH + 2) / 3;
   localparam int unsigned NI     = (DIGITS > NI_MIN) ? DIGITS : NI_MIN;
   localparam int unsigned AW     = 4 * NI;
   localparam int unsigned CW     = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONVERT = 2'd1;
   localparam logic [1:0] ST_UPDATE  = 2'd2;

   localparam logic [6:0] SEG_INV   = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   logic [1:0]          r_state;
   logic [WIDTH-1:0]    r_bin;
   logic                r_blank;
   logic [AW-1:0]       r_acc;
   logic [CW-1:0]       r_cnt;
   logic                r_done;
   logic                r_ovf;
   logic [7*DIGITS-1:0] r_hex;

   logic [AW-1:0]       w_adj;
   logic [AW-1:0]       w_step;
   logic                w_ovf;
   logic                w_seen;
   logic [3:0]          w_nib;
   logic [6:0]          w_seg;
   logic [7*DIGITS-1:0] w_hex;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // One double-dabble step: add 3 to nibbles >= 5, then shift in the next input bit.
   always_comb begin
      w_adj = r_acc;
      for (int unsigned i = 0; i < NI; i++) begin
         if (r_acc[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
         end
      end
      w_step = {w_adj[AW-2:0], r_bin[WIDTH-1]};
   end

   // Segment encoding of the finished accumulator, scanning from the top digit for blanking.
   always_comb begin
      w_ovf  = 1'b0;
      w_seen = 1'b0;
      w_nib  = 4'd0;
      w_seg  = SEG_BLANK;
      w_hex  = '0;
      for (int unsigned i = 0; i < NI; i++) begin
         if (i >= DIGITS && r_acc[4*i +: 4] != 4'd0) begin
            w_ovf = 1'b1;
         end
      end
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         w_nib = r_acc[4*k +: 4];
         if (w_nib != 4'd0) begin
            w_seen = 1'b1;
         end
         if (w_ovf) begin
            w_seg = SEG_DASH;
         end else if (r_blank && !w_seen && k != 0) begin
            w_seg = SEG_BLANK;
         end else begin
            w_seg = seg7(w_nib);
         end
         w_hex[7*k +: 7] = w_seg ^ SEG_INV;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_bin   <= '0;
         r_blank <= 1'b0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
         r_hex   <= {DIGITS{SEG_INV}};
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_bin   <= i_bin;
                  r_blank <= i_blank_lz;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               r_acc <= w_step;
               r_bin <= {r_bin[WIDTH-2:0], 1'b0};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               r_hex   <= w_hex;
               r_ovf   <= w_ovf;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy = (r_state != ST_IDLE);
   assign o_done = r_done;
   assign o_ovf  = r_ovf;
   assign o_hex  = r_hex;

endmodule

// File: tb/tb_hex_bcd_display.sv
// Randomised self-checking bench for hex_bcd_display: a 3-digit and a 2-digit instance checked
// against an arithmetic decimal/segment model.
module tb_hex_bcd_display;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start_a = 1'b0, blz_a = 1'b0;
   logic [7:0]  bin_a = '0;
   logic        busy_a, done_a, ovf_a;
   logic [20:0] hex_a;

   logic        start_b = 1'b0, blz_b = 1'b0;
   logic [7:0]  bin_b = '0;
   logic        busy_b, done_b, ovf_b;
   logic [13:0] hex_b;

   int n_checks = 0;
   int n_pass   = 0;

   logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   hex_bcd_display #(.WIDTH(8), .DIGITS(3), .ACTIVE_LOW(1'b1)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_bin(bin_a), .i_blank_lz(blz_a),
      .o_busy(busy_a), .o_done(done_a), .o_ovf(ovf_a), .o_hex(hex_a)
   );

   hex_bcd_display #(.WIDTH(8), .DIGITS(2), .ACTIVE_LOW(1'b1)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_bin(bin_b), .i_blank_lz(blz_b),
      .o_busy(busy_b), .o_done(done_b), .o_ovf(ovf_b), .o_hex(hex_b)
   );

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Decimal digits by division; active-low segments.
   function automatic logic [55:0] model_hex(input int unsigned v, input int unsigned d,
                                             input bit blz, output bit ovf);
      longint unsigned lim = 1;
      longint unsigned p   = 1;
      logic [6:0]  seg;
      logic [55:0] r = '0;
      for (int k = 0; k < int'(d); k++) lim = lim * 10;
      ovf = (v >= lim);
      for (int k = 0; k < int'(d); k++) begin
         if (ovf)                           seg = 7'h40;
         else if (blz && k > 0 && v < p)    seg = 7'h00;
         else                               seg = seg_tab[(v / p) % 10];
         r[7*k +: 7] = seg ^ 7'h7F;
         p = p * 10;
      end
      return r;
   endfunction

   task automatic conv_a(input logic [7:0] v, input bit blz, input int intr_edge,
                         input logic [7:0] intr_v);
      int busy_cnt = 0, done_edge = -1, n_done = 0;
      bit eo;
      logic [55:0] eh;
      @(posedge clk); #1;
      start_a = 1'b1; bin_a = v; blz_a = blz;
      for (int e = 1; e <= W + 6; e++) begin
         @(posedge clk); #1;
         if (e == 1) start_a = 1'b0;
         if (e == intr_edge) begin start_a = 1'b1; bin_a = intr_v; end
         if (e == intr_edge + 1) start_a = 1'b0;
         if (busy_a) busy_cnt++;
         if (done_a) begin
            n_done++;
            if (done_edge < 0) done_edge = e;
         end
      end
      eh = model_hex(v, 3, blz, eo);
      check("done_edge", longint'(done_edge), W + 2);
      check("done_count", n_done, 1);
      check("busy_cycles", busy_cnt, W + 1);
      check("hex_a", hex_a, eh[20:0]);
      check("ovf_a", ovf_a, eo);
   endtask

   task automatic conv_b(input logic [7:0] v, input bit blz);
      bit got_done = 1'b0;
      bit eo;
      logic [55:0] eh;
      @(posedge clk); #1;
      start_b = 1'b1; bin_b = v; blz_b = blz;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int e = 0; e < 30 && !got_done; e++) begin
         @(posedge clk); #1;
         if (done_b) got_done = 1'b1;
      end
      eh = model_hex(v, 2, blz, eo);
      check("done_b", got_done, 1);
      check("hex_b", hex_b, eh[13:0]);
      check("ovf_b", ovf_b, eo);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen_done;
      #12;
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_hex_a", hex_a, 21'h1FFFFF);
      check("rst_hex_b", hex_b, 14'h3FFF);
      @(negedge clk);
      rst = 1'b0;

      conv_a(8'd255, 1'b0, 0, 8'd0);
      conv_a(8'd7, 1'b1, 0, 8'd0);
      conv_a(8'd0, 1'b1, 0, 8'd0);
      conv_a(8'd0, 1'b0, 0, 8'd0);
      conv_a(8'd200, 1'b0, 3, 8'd17);
      conv_b(8'd100, 1'b0);
      conv_b(8'd99, 1'b0);
      conv_b(8'd5, 1'b1);

      for (int i = 0; i < 12; i++) begin
         conv_a(8'($urandom_range(0, 255)), 1'($urandom % 2), 0, 8'd0);
         conv_b(8'($urandom_range(0, 255)), 1'($urandom % 2));
      end

      // Asynchronous reset in the middle of a conversion.
      @(posedge clk); #1;
      start_a = 1'b1; bin_a = 8'd123; blz_a = 1'b0;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", busy_a, 0);
      check("mid_rst_hex", hex_a, 21'h1FFFFF);
      check("mid_rst_done", done_a, 0);
      @(posedge clk); #3;
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done_a) seen_done = 1'b1;
      end
      check("mid_rst_no_done", seen_done, 0);
      conv_a(8'd123, 1'b0, 0, 8'd0);
      conv_a(8'd42, 1'b1, 0, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hex_bcd_display.md
HEX_BCD_DISPLAY -- requirements
Module: hex_bcd_display

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: binary input width, legal 4..32.
REQ-002 The block SHALL have parameter DIGITS, default 3: number of seven-segment digits driven, legal 1..8.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1: when 1, every HEX bit is inverted (segment lit = 0).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port START, input, 1 bit: conversion request, sampled on the CLK rising edge.
REQ-007 The block SHALL have port BIN, input, WIDTH bits: unsigned value to display, sampled with START.
REQ-008 The block SHALL have port BLANK_LZ, input, 1 bit: leading-zero blanking enable, sampled with START.
REQ-009 The block SHALL have port BUSY, output, 1 bit: conversion in progress.
REQ-010 The block SHALL have port DONE, output, 1 bit: one-cycle pulse when HEX/OVF update.
REQ-011 The block SHALL have port OVF, output, 1 bit: last value exceeded 10^DIGITS-1.
REQ-012 The block SHALL have port HEX, output, 7*DIGITS bits: digit k on HEX[7k+6:7k], bit 0 = segment a ... bit 6 = segment g; digit 0 least significant.

Function
REQ-013 The FSM SHALL have states IDLE, CONVERT, UPDATE.
REQ-014 In IDLE with START=1, the block SHALL latch BIN and BLANK_LZ, clear the BCD accumulator, and enter CONVERT.
REQ-015 CONVERT SHALL run exactly WIDTH cycles of double-dabble: add 3 to each BCD nibble >= 5, then shift left one bit with the next BIN bit, MSB first.
REQ-016 The internal BCD accumulator SHALL hold NI = max(DIGITS, ceil(WIDTH/3)) nibbles so no input value is truncated internally.
REQ-017 After WIDTH CONVERT cycles the FSM SHALL enter UPDATE for one cycle, then return to IDLE.
REQ-018 BUSY SHALL be 1 exactly while in CONVERT or UPDATE; with START asserted at edge 0, BUSY is high after edges 1..WIDTH+1 and low after edge WIDTH+2.
REQ-019 DONE SHALL be high for exactly the one cycle following the UPDATE state; HEX and OVF SHALL change on the same edge that raises DONE.
REQ-020 HEX and OVF SHALL hold their value between DONE pulses.
REQ-021 START while BUSY=1 SHALL be ignored, with no queuing; START held high in IDLE on the DONE cycle SHALL begin a new conversion.
REQ-022 OVF SHALL be 1 iff any accumulator nibble at index >= DIGITS is non-zero.
REQ-023 When OVF=1, every digit SHALL show a dash (segment g only).
REQ-024 Digit encoding SHALL be, active-high hex, 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F, dash:40, blank:00; apply ACTIVE_LOW inversion after encoding.
REQ-025 With latched BLANK_LZ=1, zero digits above the most significant non-zero digit SHALL be blank.
REQ-026 With latched BLANK_LZ=1 and value 0, digit 0 SHALL still show "0".
REQ-027 With latched BLANK_LZ=0, all DIGITS digits SHALL be shown, zero-padded.
REQ-028 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 RST=1 SHALL immediately force IDLE, BUSY=0, DONE=0, OVF=0, and all HEX segments unlit (all 1s when ACTIVE_LOW=1), regardless of clock.
REQ-030 RST asserted mid-conversion SHALL abort it with no DONE pulse; after release the block SHALL accept START on the first clock edge.

Verification (WIDTH=8, DIGITS=3, ACTIVE_LOW=1 unless stated)
REQ-031 Bench SHALL cover: BIN=255, BLANK_LZ=0, START one cycle -> BUSY for 9 cycles, DONE pulse at edge 10, HEX digits 2/1/0 = 24/12/12, OVF=0.
REQ-032 Bench SHALL cover: BIN=7, BLANK_LZ=1 -> digits 2/1 = 7F (blank), digit 0 = 78; BIN=0, BLANK_LZ=1 -> digit 0 = 40, others 7F.
REQ-033 Bench SHALL cover: BIN=0, BLANK_LZ=0 -> all digits 40.
REQ-034 Bench SHALL cover: DIGITS=2, BIN=100 -> OVF=1, both digits 3F (dash); then BIN=99 -> OVF=0, digits 10/10.
REQ-035 Bench SHALL cover: START pulsed again at cycle 3 of a conversion with a different BIN -> ignored; result matches the first BIN, exactly one DONE.
REQ-036 Bench SHALL cover: RST pulsed asynchronously (between edges) at cycle 4 of a conversion -> BUSY=0 and HEX all 1s immediately, no DONE; a new START after release converts correctly.
